// File: rtl/sram_bridge_2x1_arbiter.sv
// Merges the inst/data cache SRAM-like ports onto one master port with a single outstanding transaction.
// Issue is zero-latency from IDLE, and the grant holds until m_addr_ok; there is one bubble cycle after data_ok.
module sram_bridge_2x1_arbiter #(
  parameter int RR_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_last;
  logic   w_last_nxt;
  logic   w_win;
  logic   w_sel;
  logic   w_own_req;

  // Owner/winner encoding: 0 = inst, 1 = data.
  always_comb begin
    if (inst_req && data_req) begin
      w_win = (RR_MODE != 0) ? ~r_last : 1'b1;
    end else begin
      w_win = data_req;
    end
  end

  assign w_own_req = r_owner ? data_req : inst_req;

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_sel        = r_owner;
    m_req        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          w_sel       = w_win;
          m_req       = 1'b1;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          if (m_addr_ok) begin
            inst_addr_ok = ~w_win;
            data_addr_ok = w_win;
            w_state_nxt  = S_WAIT;
          end else begin
            w_state_nxt  = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        m_req = w_own_req;
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
        end else if (m_addr_ok) begin
          inst_addr_ok = ~r_owner;
          data_addr_ok = r_owner;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_data_ok) begin
          inst_data_ok = ~r_owner;
          data_data_ok = r_owner;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Handshakes are suppressed while reset is held so nothing leaks from a stale state.
    if (!rst) begin
      m_req        = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

  assign m_wr       = w_sel ? data_wr    : inst_wr;
  assign m_size     = w_sel ? data_size  : inst_size;
  assign m_addr     = w_sel ? data_addr  : inst_addr;
  assign m_wdata    = w_sel ? data_wdata : inst_wdata;
  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= (RR_MODE != 0) ? w_last_nxt : 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_bridge_2x1_arbiter.sv
// Drives a fixed-priority and a round-robin bridge side by side and checks both against a transaction-level model.
module tb_sram_bridge_2x1_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        inst_req     [2];
  logic        inst_wr      [2];
  logic [1:0]  inst_size    [2];
  logic [31:0] inst_addr    [2];
  logic [31:0] inst_wdata   [2];
  logic [31:0] inst_rdata   [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic        data_req     [2];
  logic        data_wr      [2];
  logic [1:0]  data_size    [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic [31:0] data_rdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic        m_req        [2];
  logic        m_wr         [2];
  logic [1:0]  m_size       [2];
  logic [31:0] m_addr       [2];
  logic [31:0] m_wdata      [2];
  logic [31:0] m_rdata      [2];
  logic        m_addr_ok    [2];
  logic        m_data_ok    [2];

  sram_bridge_2x1_arbiter #(.RR_MODE(0)) u_fixed (
    .clk(clk), .rst(rst[0]),
    .inst_req(inst_req[0]), .inst_wr(inst_wr[0]), .inst_size(inst_size[0]),
    .inst_addr(inst_addr[0]), .inst_wdata(inst_wdata[0]), .inst_rdata(inst_rdata[0]),
    .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]),
    .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]), .data_rdata(data_rdata[0]),
    .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]),
    .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .m_addr_ok(m_addr_ok[0]), .m_data_ok(m_data_ok[0])
  );

  sram_bridge_2x1_arbiter #(.RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst[1]),
    .inst_req(inst_req[1]), .inst_wr(inst_wr[1]), .inst_size(inst_size[1]),
    .inst_addr(inst_addr[1]), .inst_wdata(inst_wdata[1]), .inst_rdata(inst_rdata[1]),
    .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]),
    .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]), .data_rdata(data_rdata[1]),
    .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]),
    .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .m_addr_ok(m_addr_ok[1]), .m_data_ok(m_data_ok[1])
  );

  // Model: 0 = no transaction, 1 = granted awaiting acceptance, 2 = accepted awaiting response.
  int          mphase [2];
  logic        mown   [2];
  logic        mlast  [2];
  logic [31:0] mseq   [2];
  logic [31:0] dseq   [2];
  int          mcnt   [2];
  int          dcnt   [2];
  int          mbase  [2];
  int          dbase  [2];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic e_req, e_iao, e_ido, e_dao, e_ddo, g, sel, nown, nlast;
      logic [66:0] e_fld;
      int nph;
      e_req = 1'b0; e_iao = 1'b0; e_ido = 1'b0; e_dao = 1'b0; e_ddo = 1'b0;
      g = 1'b0; sel = mown[k]; nown = mown[k]; nlast = mlast[k]; nph = mphase[k];
      if (!rst[k]) begin
        nph = 0; nown = 1'b0; nlast = 1'b0;
      end else if (mphase[k] == 0) begin
        if (inst_req[k] || data_req[k]) begin
          if (inst_req[k] && data_req[k]) g = (k == 1) ? ~mlast[k] : 1'b1;
          else g = data_req[k];
          sel = g; e_req = 1'b1; nown = g; nlast = g;
          if (m_addr_ok[k]) begin
            e_iao = ~g; e_dao = g; nph = 2;
          end else begin
            nph = 1;
          end
        end
      end else if (mphase[k] == 1) begin
        if (mown[k] ? data_req[k] : inst_req[k]) begin
          e_req = 1'b1;
          if (m_addr_ok[k]) begin
            e_iao = ~mown[k]; e_dao = mown[k]; nph = 2;
          end
        end else begin
          nph = 0;
        end
      end else if (m_data_ok[k]) begin
        e_ido = ~mown[k]; e_ddo = mown[k]; nph = 0;
      end
      if (rst[k] && mphase[k] != 2)
        assert (!(m_addr_ok[k] && m_data_ok[k])) else $error("downstream handshake overlap dut%0d", k);
      check("ctl", k, {m_req[k], inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k], data_data_ok[k]},
            {e_req, e_iao, e_ido, e_dao, e_ddo});
      check("rdata", k, {inst_rdata[k], data_rdata[k]}, {m_rdata[k], m_rdata[k]});
      if (e_req) begin
        e_fld = sel ? {data_wr[k], data_size[k], data_addr[k], data_wdata[k]}
                    : {inst_wr[k], inst_size[k], inst_addr[k], inst_wdata[k]};
        check("fields", k, {m_wr[k], m_size[k], m_addr[k], m_wdata[k]}, e_fld);
      end
      if (e_iao || e_dao) begin
        mseq[k] = {mseq[k][30:0], e_dao}; mcnt[k]++;
      end
      if (inst_addr_ok[k] === 1'b1 || data_addr_ok[k] === 1'b1) begin
        dseq[k] = {dseq[k][30:0], data_addr_ok[k]}; dcnt[k]++;
      end
      mphase[k] = nph; mown[k] = nown; mlast[k] = nlast;
    end
  endtask

  task automatic mid();
    @(negedge clk);
    compare_all();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    mid();
    nxt();
  endtask

  task automatic idle_in();
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b0; inst_wr[k] = 1'b0; inst_size[k] = 2'd0; inst_addr[k] = '0; inst_wdata[k] = '0;
      data_req[k] = 1'b0; data_wr[k] = 1'b0; data_size[k] = 2'd0; data_addr[k] = '0; data_wdata[k] = '0;
      m_rdata[k] = '0; m_addr_ok[k] = 1'b0; m_data_ok[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; inst_req[k] = 1'b1; m_addr_ok[k] = 1'b1;
    end
    mid();
    for (int k = 0; k < 2; k++) check("rst_forced", k, {m_req[k], inst_addr_ok[k], data_addr_ok[k]}, 3'b000);
    nxt();
    idle_in();
    cyc();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; mbase[k] = mcnt[k]; dbase[k] = dcnt[k];
    end
  endtask

  task automatic chk_log(input string nm, input int k, input int n, input logic [31:0] pat);
    logic [31:0] msk;
    msk = (32'd1 << n) - 32'd1;
    check({nm, "_dut"}, k, {dcnt[k] - dbase[k], dseq[k] & msk}, {n, pat});
    check({nm, "_model"}, k, {mcnt[k] - mbase[k], mseq[k] & msk}, {n, pat});
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; mphase[k] = 0; mown[k] = 1'b0; mlast[k] = 1'b0;
      mseq[k] = '0; dseq[k] = '0; mcnt[k] = 0; dcnt[k] = 0; mbase[k] = 0; dbase[k] = 0;
    end
    idle_in();
    nxt();

    // Single inst read with a three-cycle response.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'hBFC0_0000; inst_size[k] = 2'd2; m_addr_ok[k] = 1'b1;
    end
    mid();
    for (int k = 0; k < 2; k++) check("t1_issue", k, {m_req[k], inst_addr_ok[k], m_addr[k]}, {2'b11, 32'hBFC0_0000});
    nxt();
    for (int k = 0; k < 2; k++) begin inst_req[k] = 1'b0; m_addr_ok[k] = 1'b0; end
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin m_data_ok[k] = 1'b1; m_rdata[k] = 32'h3C08_0001; end
    mid();
    for (int k = 0; k < 2; k++)
      check("t1_resp", k, {inst_data_ok[k], inst_rdata[k], data_addr_ok[k], data_data_ok[k]}, {1'b1, 32'h3C08_0001, 2'b00});
    nxt();
    idle_in();
    for (int k = 0; k < 2; k++) chk_log("t1_log", k, 1, 32'h0);

    // Simultaneous requests after reset: data first in both modes, inst right after the bubble.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'h1000; inst_size[k] = 2'd2;
      data_req[k] = 1'b1; data_wr[k] = 1'b1; data_addr[k] = 32'h2000; data_wdata[k] = 32'hDEAD_BEEF; data_size[k] = 2'd2;
      m_addr_ok[k] = 1'b1;
    end
    mid();
    for (int k = 0; k < 2; k++)
      check("t2_data", k, {m_wr[k], m_size[k], m_addr[k], m_wdata[k], data_addr_ok[k], inst_addr_ok[k]},
            {1'b1, 2'd2, 32'h2000, 32'hDEAD_BEEF, 2'b10});
    nxt();
    for (int k = 0; k < 2; k++) begin data_req[k] = 1'b0; m_addr_ok[k] = 1'b0; m_data_ok[k] = 1'b1; end
    mid();
    for (int k = 0; k < 2; k++) check("t2_wait", k, {data_data_ok[k], m_req[k], inst_addr_ok[k]}, 3'b100);
    nxt();
    for (int k = 0; k < 2; k++) begin m_data_ok[k] = 1'b0; m_addr_ok[k] = 1'b1; end
    mid();
    for (int k = 0; k < 2; k++) check("t2_inst", k, {m_req[k], inst_addr_ok[k], m_wr[k], m_addr[k]}, {3'b110, 32'h1000});
    nxt();
    for (int k = 0; k < 2; k++) begin inst_req[k] = 1'b0; m_addr_ok[k] = 1'b0; m_data_ok[k] = 1'b1; end
    cyc();
    idle_in();
    for (int k = 0; k < 2; k++) chk_log("t2_order", k, 2, 32'b10);

    // Continuous contention for four transactions.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b1; inst_addr[k] = 32'h100; data_req[k] = 1'b1; data_addr[k] = 32'h200;
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin m_addr_ok[k] = (c % 2 == 0); m_data_ok[k] = (c % 2 == 1); end
      cyc();
    end
    idle_in();
    chk_log("t3_fixed", 0, 4, 32'b1111);
    chk_log("t3_rr", 1, 4, 32'b1010);

    // Grant lock: data arrives while inst waits for acceptance.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        inst_req[k] = (c <= 5); inst_addr[k] = 32'h3000;
        data_req[k] = (c >= 1 && c <= 8); data_addr[k] = 32'h4000;
        m_addr_ok[k] = (c == 5 || c == 8); m_data_ok[k] = (c == 7 || c == 9);
      end
      mid();
      for (int k = 0; k < 2; k++) begin
        if (c < 5) check("t4_hold", k, {m_req[k], m_addr[k], data_addr_ok[k], inst_addr_ok[k]}, {1'b1, 32'h3000, 2'b00});
        else if (c == 5) check("t4_acc", k, {inst_addr_ok[k], m_addr[k]}, {1'b1, 32'h3000});
        else if (c == 6) check("t4_wait", k, {m_req[k], data_addr_ok[k]}, 2'b00);
        else if (c == 7) check("t4_resp", k, {inst_data_ok[k], data_addr_ok[k]}, 2'b10);
        else if (c == 8) check("t4_data", k, {data_addr_ok[k], m_addr[k]}, {1'b1, 32'h4000});
      end
      nxt();
    end
    idle_in();

    // Reset while a data read is outstanding, then a stray response.
    do_reset();
    for (int k = 0; k < 2; k++) begin data_req[k] = 1'b1; data_addr[k] = 32'h5000; m_addr_ok[k] = 1'b1; end
    cyc();
    for (int k = 0; k < 2; k++) begin data_req[k] = 1'b0; m_addr_ok[k] = 1'b0; rst[k] = 1'b0; end
    mid();
    for (int k = 0; k < 2; k++) check("t5_inrst", k, {data_data_ok[k], m_req[k]}, 2'b00);
    nxt();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; m_data_ok[k] = 1'b1; inst_req[k] = 1'b1; inst_addr[k] = 32'h6000;
    end
    mid();
    for (int k = 0; k < 2; k++)
      check("t5_stray", k, {data_data_ok[k], inst_data_ok[k], m_req[k], m_addr[k]}, {3'b001, 32'h6000});
    nxt();
    for (int k = 0; k < 2; k++) begin m_data_ok[k] = 1'b0; m_addr_ok[k] = 1'b1; end
    mid();
    for (int k = 0; k < 2; k++) check("t5_acc", k, inst_addr_ok[k], 1'b1);
    nxt();
    for (int k = 0; k < 2; k++) begin inst_req[k] = 1'b0; m_addr_ok[k] = 1'b0; m_data_ok[k] = 1'b1; end
    cyc();
    idle_in();

    // Back-to-back from one requester: one transaction per two cycles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        data_req[k] = 1'b1; data_addr[k] = 32'h7000 + 32'(4 * (c / 2));
        m_addr_ok[k] = (c % 2 == 0); m_data_ok[k] = (c % 2 == 1);
      end
      mid();
      for (int k = 0; k < 2; k++) begin
        if (c % 2 == 0) check("t6_issue", k, {m_req[k], data_addr_ok[k], m_addr[k]}, {2'b11, 32'h7000 + 32'(4 * (c / 2))});
        else check("t6_wait", k, {m_req[k], data_data_ok[k]}, 2'b01);
      end
      nxt();
    end
    idle_in();
    for (int k = 0; k < 2; k++) chk_log("t6_log", k, 4, 32'b1111);

    // Random traffic, including protocol violations and mid-transaction resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]        = ($urandom_range(0, 63) != 0);
        inst_req[k]   = $urandom_range(0, 2) != 0;
        inst_wr[k]    = $urandom_range(0, 1) == 1;
        inst_size[k]  = 2'($urandom_range(0, 2));
        inst_addr[k]  = $urandom;
        inst_wdata[k] = $urandom;
        data_req[k]   = $urandom_range(0, 2) != 0;
        data_wr[k]    = $urandom_range(0, 1) == 1;
        data_size[k]  = 2'($urandom_range(0, 2));
        data_addr[k]  = $urandom;
        data_wdata[k] = $urandom;
        m_rdata[k]    = $urandom;
        m_addr_ok[k]  = $urandom_range(0, 1) == 1;
        m_data_ok[k]  = $urandom_range(0, 1) == 1;
        if (m_addr_ok[k] && m_data_ok[k] && mphase[k] != 2) m_data_ok[k] = 1'b0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_bridge_2x1_arbiter.md
Name: sram_bridge_2x1_arbiter

Overview:
- Merges the instruction-cache and data-cache SRAM-like miss/uncached ports into one SRAM-like master port toward the downstream AXI bridge.
- Sits directly below the cache pair.
- Allows one outstanding transaction at a time and routes addr_ok, data_ok and rdata back to the owning requester.
- Arbitration is either fixed data-priority or round-robin.

Parameters:
- RR_MODE, 0: 0 = data port always wins a tie; 1 = round-robin, the loser of the last grant wins the next tie.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- inst_req  in  1  inst requester request
- inst_wr  in  1  write enable
- inst_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_rdata  out  32  read data
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  response returned
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meaning, data requester
- m_req  out  1  master request
- m_wr  out  1  write enable
- m_size  out  2  size
- m_addr  out  32  address
- m_wdata  out  32  write data
- m_rdata  in  32  read data
- m_addr_ok  in  1  request accepted downstream
- m_data_ok  in  1  response downstream

Behaviour:
- State register: IDLE, LOCK (granted, waiting for m_addr_ok), WAIT (accepted, waiting for m_data_ok).
- Registered owner bit: 0 = inst, 1 = data.
- RR_MODE=1 adds a registered last-grant bit.
- Reset (rst=0 at clk edge): state=IDLE, owner=0, last-grant=0.
- While rst=0, m_req, all addr_ok and all data_ok are forced 0 combinationally.
- IDLE:
  - If no req: m_req=0, stay.
  - Otherwise select a winner combinationally:
    - Only one requester asserting: that requester.
    - Both, RR_MODE=0: data.
    - Both, RR_MODE=1: the port that was not last granted.
  - Drive m_req=1 and m_wr/m_size/m_addr/m_wdata from the winner in the same cycle (zero-latency issue).
  - Latch owner=winner and update last-grant.
  - m_addr_ok=1 same cycle: winner's addr_ok=1, next state WAIT.
  - Otherwise: next state LOCK.
- LOCK:
  - Mux fixed to owner; m_req = owner's req.
  - Other requester ignored, even if it has priority.
  - m_addr_ok=1: owner addr_ok=1, next state WAIT.
  - Owner drops req before acceptance (protocol violation): return to IDLE, no addr_ok.
- WAIT:
  - m_req=0.
  - m_data_ok=1: owner data_ok=1 same cycle, next state IDLE.
  - New arbitration starts the following cycle (one-cycle bubble between transactions).
- addr_ok and data_ok are combinational pass-through, qualified by state and owner; never asserted to the non-owner.
- m_rdata is broadcast to both inst_rdata and data_rdata; it is valid only with the matching data_ok.
- m_addr_ok outside IDLE/LOCK is ignored.
- m_data_ok outside WAIT is ignored and not forwarded; this covers stray responses after a mid-transaction reset.
- Reset mid-transaction: the outstanding transaction is abandoned and neither requester sees data_ok for it.
- m_addr_ok and m_data_ok in the same cycle while in IDLE/LOCK: addr_ok honoured, data_ok dropped. Downstream never does this; assertion in the bench.
- No width conversion; size/addr/wdata are passed unmodified.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000, m_addr_ok on cycle 0, m_data_ok on cycle 3 with m_rdata=0x3C080001 -> m_addr=0xBFC00000 on cycle 0; inst_addr_ok on cycle 0; inst_data_ok with rdata 0x3C080001 on cycle 3; data_* ok never asserted.
- Simultaneous requests, RR_MODE=0, inst addr 0x1000, data write addr 0x2000 wdata 0xDEADBEEF size 2 -> data served first (m_wr=1, m_addr=0x2000); inst issued in the cycle after data_data_ok; order data, inst.
- RR_MODE=1, both requesting continuously for 4 transactions -> grants alternate data, inst, data, inst. The first is data because last-grant resets to inst.
- Grant lock: inst granted, m_addr_ok held low 5 cycles, data_req raised on cycle 1 -> m_addr stays inst address all 5 cycles; data_addr_ok stays 0 until after the inst data_ok.
- Reset mid-op: data read accepted, rst=0 for 1 cycle before m_data_ok, then m_data_ok pulses -> no data_data_ok; state IDLE; the next inst_req is issued immediately.
- Back-to-back same requester with m_addr_ok and m_data_ok each 1 cycle -> exactly one transaction per 2 cycles; m_req low during WAIT.
